// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module  : busca_instrucao
// Brief   : Instruction fetch unit: 3-state fetch from a synchronous ROM with
//           valid/ready hand-off to decode, PC redirects and a link register.
// Revision: 1.0 - initial release
// ============================================================================
module busca_instrucao #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_q,
    output logic [31:0]       pc,
    output logic [15:0]       inst,
    output logic [3:0]        codop,
    output logic [3:0]        s4,
    output logic [3:0]        s3,
    output logic [3:0]        s2,
    output logic [11:0]       imm,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              EscCP,
    input  logic              EscCondCP,
    input  logic              cond,
    input  logic [1:0]        FonteCP,
    input  logic [15:0]       alvo,
    input  logic              EscLR,
    output logic [31:0]       lr
);

    typedef enum logic [1:0] {
        BUSCA   = 2'd0,
        ESPERA  = 2'd1,
        ENTREGA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [15:0] r_inst;
    logic [31:0] r_lr;
    logic        w_load_inst;
    logic        w_take;
    logic [31:0] w_pc_plus1;
    logic [31:0] w_imm_sext;
    logic [31:0] w_target;

    assign w_take     = EscCP | (EscCondCP & cond);
    assign w_pc_plus1 = r_pc + 32'd1;
    assign w_imm_sext = {{20{r_inst[11]}}, r_inst[11:0]};

    always_comb begin
        w_target = w_pc_plus1;
        case (FonteCP)
            2'b00:   w_target = w_pc_plus1;
            2'b01:   w_target = w_pc_plus1 + w_imm_sext;
            2'b10:   w_target = {r_pc[31:12], r_inst[11:0]};
            default: w_target = {16'h0000, alvo};
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_load_inst  = 1'b0;
        case (r_state)
            BUSCA: begin
                w_next_state = ESPERA;
            end
            ESPERA: begin
                w_next_state = ENTREGA;
                w_load_inst  = 1'b1;
            end
            ENTREGA: begin
                if (inst_ready) begin
                    w_next_state = BUSCA;
                    w_pc_next    = w_pc_plus1;
                end
            end
            default: begin
                w_next_state = BUSCA;
            end
        endcase
        // A redirect overrides everything: the fetch in flight is dropped and
        // the accepted-instruction increment never happens.
        if (w_take) begin
            w_next_state = BUSCA;
            w_pc_next    = w_target;
            w_load_inst  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUSCA;
            r_pc    <= 32'd0;
            r_inst  <= 16'd0;
            r_lr    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (w_load_inst) begin
                r_inst <= mem_q;
            end
            if (EscLR) begin
                r_lr <= w_pc_plus1;
            end
        end
    end

    assign mem_addr   = r_pc[ADDR_W-1:0];
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign lr         = r_lr;
    assign inst_valid = (r_state == ENTREGA);
    assign codop      = r_inst[15:12];
    assign s4         = r_inst[11:8];
    assign s3         = r_inst[7:4];
    assign s2         = r_inst[3:0];
    assign imm        = r_inst[11:0];

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module  : tb_busca_instrucao
// Brief   : Directed self-checking bench for busca_instrucao with a ROM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_busca_instrucao;

    logic        clk;
    logic        reset;
    logic [7:0]  mem_addr;
    logic [15:0] mem_q;
    logic [31:0] pc;
    logic [15:0] inst;
    logic [3:0]  codop, s4, s3, s2;
    logic [11:0] imm;
    logic        inst_valid;
    logic        inst_ready;
    logic        EscCP, EscCondCP, cond;
    logic [1:0]  FonteCP;
    logic [15:0] alvo;
    logic        EscLR;
    logic [31:0] lr;

    int checks;
    int errors;

    logic [15:0] rom [0:255];

    busca_instrucao #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_q(mem_q),
        .pc(pc), .inst(inst), .codop(codop), .s4(s4), .s3(s3), .s2(s2),
        .imm(imm), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .EscCP(EscCP), .EscCondCP(EscCondCP), .cond(cond), .FonteCP(FonteCP),
        .alvo(alvo), .EscLR(EscLR), .lr(lr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= rom[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        EscCP = 0; EscCondCP = 0; cond = 0; FonteCP = 2'b00; alvo = 16'h0; EscLR = 0;
    endtask

    task automatic test_reset();
        reset = 1; inst_ready = 0; clear_ctrl();
        #2;
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h expected %h", pc, 32'd0); end
        checks++; if (inst !== 16'd0) begin errors++; $display("FAIL reset_inst got %h expected %h", inst, 16'd0); end
        checks++; if (lr !== 32'd0) begin errors++; $display("FAIL reset_lr got %h expected %h", lr, 32'd0); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", inst_valid); end
        tick();
        reset = 0;
    endtask

    task automatic test_fetch();
        inst_ready = 1;
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL fetch_first_addr got %h expected 00", mem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_c1_valid got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_c2_valid got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fetch_c3_valid got %b expected 1", inst_valid); end
        checks++; if (inst !== 16'h1234) begin errors++; $display("FAIL fetch_c3_inst got %h expected 1234", inst); end
        checks++; if ({codop, s4, s3, s2} !== 16'h1234) begin errors++; $display("FAIL fetch_fields got %h%h%h%h expected 1234", codop, s4, s3, s2); end
        checks++; if (imm !== 12'h234) begin errors++; $display("FAIL fetch_imm got %h expected 234", imm); end
        tick();
        checks++; if (pc !== 32'd1 || inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_c4 got pc=%h valid=%b expected pc=1 valid=0", pc, inst_valid); end
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1 || inst !== 16'h5678) begin errors++; $display("FAIL fetch_c6 got valid=%b inst=%h expected 1/5678", inst_valid, inst); end
        tick();
        checks++; if (pc !== 32'd2) begin errors++; $display("FAIL fetch_pc2 got %h expected 2", pc); end
        inst_ready = 0;
    endtask

    task automatic test_stall();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== 16'h9ABC || pc !== 32'd2) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%b inst=%h pc=%h expected 1/9abc/2", i, inst_valid, inst, pc);
            end
            tick();
        end
        inst_ready = 1;
        tick();
        checks++; if (pc !== 32'd3 || inst_valid !== 1'b0) begin errors++; $display("FAIL stall_accept got pc=%h valid=%b expected 3/0", pc, inst_valid); end
        inst_ready = 0;
    endtask

    task automatic test_cond();
        EscCP = 1; FonteCP = 2'b11; alvo = 16'h0010;
        tick();
        clear_ctrl();
        checks++; if (pc !== 32'h10 || mem_addr !== 8'h10) begin errors++; $display("FAIL cond_setup got pc=%h addr=%h expected 10/10", pc, mem_addr); end
        tick();
        tick();
        checks++; if (inst !== 16'h0FFE || inst_valid !== 1'b1) begin errors++; $display("FAIL cond_inst got %h valid=%b expected 0ffe/1", inst, inst_valid); end
        EscCondCP = 1; FonteCP = 2'b01; cond = 0;
        tick();
        checks++; if (pc !== 32'h10 || inst_valid !== 1'b1) begin errors++; $display("FAIL cond_false got pc=%h valid=%b expected 10/1", pc, inst_valid); end
        cond = 1;
        tick();
        checks++; if (pc !== 32'h0F || inst_valid !== 1'b0) begin errors++; $display("FAIL cond_true got pc=%h valid=%b expected 0f/0", pc, inst_valid); end
        checks++; if (inst !== 16'h0FFE) begin errors++; $display("FAIL cond_inst_kept got %h expected 0ffe", inst); end
        clear_ctrl();
    endtask

    task automatic test_back_to_back();
        EscCP = 1; FonteCP = 2'b11; alvo = 16'h0020;
        tick();
        clear_ctrl();
        tick();
        tick();
        checks++; if (inst !== 16'h3456 || pc !== 32'h20) begin errors++; $display("FAIL b2b_setup got inst=%h pc=%h expected 3456/20", inst, pc); end
        inst_ready = 1; EscCP = 1; FonteCP = 2'b11; alvo = 16'hBEEF; EscLR = 1;
        tick();
        checks++; if (pc !== 32'h0000BEEF) begin errors++; $display("FAIL b2b_pc got %h expected 0000beef", pc); end
        checks++; if (lr !== 32'h21) begin errors++; $display("FAIL b2b_lr got %h expected 21", lr); end
        checks++; if (inst_valid !== 1'b0 || inst !== 16'h3456) begin errors++; $display("FAIL b2b_inst got valid=%b inst=%h expected 0/3456", inst_valid, inst); end
        inst_ready = 0; clear_ctrl();
        tick();
        EscCP = 1; FonteCP = 2'b00;
        tick();
        clear_ctrl();
        checks++; if (pc !== 32'h0000BEF0 || inst !== 16'h3456 || inst_valid !== 1'b0) begin errors++; $display("FAIL espera_redirect got pc=%h inst=%h valid=%b expected bef0/3456/0", pc, inst, inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL espera_no_pulse got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst !== 16'h0ABC || inst_valid !== 1'b1) begin errors++; $display("FAIL abs_inst got %h valid=%b expected 0abc/1", inst, inst_valid); end
        EscCP = 1; FonteCP = 2'b10;
        tick();
        clear_ctrl();
        checks++; if (pc !== 32'h0000BABC) begin errors++; $display("FAIL abs_target got %h expected 0000babc", pc); end
        checks++; if (lr !== 32'h21) begin errors++; $display("FAIL lr_held got %h expected 21", lr); end
    endtask

    task automatic test_wrap();
        reset = 1;
        tick();
        reset = 0;
        tick();
        tick();
        checks++; if (inst !== 16'h0FFE || pc !== 32'd0) begin errors++; $display("FAIL wrap_setup got inst=%h pc=%h expected 0ffe/0", inst, pc); end
        EscCP = 1; FonteCP = 2'b01; EscLR = 1;
        tick();
        clear_ctrl();
        checks++; if (pc !== 32'hFFFFFFFF || mem_addr !== 8'hFF) begin errors++; $display("FAIL rel_negative got pc=%h addr=%h expected ffffffff/ff", pc, mem_addr); end
        checks++; if (lr !== 32'd1) begin errors++; $display("FAIL wrap_lr1 got %h expected 1", lr); end
        tick();
        tick();
        checks++; if (inst !== 16'h7ABC) begin errors++; $display("FAIL wrap_inst got %h expected 7abc", inst); end
        inst_ready = 1; EscLR = 1;
        tick();
        inst_ready = 0; clear_ctrl();
        checks++; if (pc !== 32'd0 || mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc got pc=%h addr=%h expected 0/00", pc, mem_addr); end
        checks++; if (lr !== 32'd0) begin errors++; $display("FAIL wrap_lr got %h expected 0", lr); end
    endtask

    task automatic test_reset_midfetch();
        tick();
        tick();
        inst_ready = 1; EscLR = 1;
        tick();
        inst_ready = 0; clear_ctrl();
        tick();
        checks++; if (pc !== 32'd1 || lr !== 32'd1) begin errors++; $display("FAIL mid_setup got pc=%h lr=%h expected 1/1", pc, lr); end
        #2;
        reset = 1;
        #1;
        checks++; if (pc !== 32'd0 || inst !== 16'd0 || lr !== 32'd0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got pc=%h inst=%h lr=%h valid=%b expected zeros", pc, inst, lr, inst_valid);
        end
        tick();
        reset = 0;
        checks++; if (mem_addr !== 8'h00 || inst_valid !== 1'b0) begin errors++; $display("FAIL mid_restart got addr=%h valid=%b expected 00/0", mem_addr, inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst !== 16'h0FFE) begin errors++; $display("FAIL mid_refetch got valid=%b inst=%h expected 1/0ffe", inst_valid, inst); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h1234;
        rom[8'h01] = 16'h5678;
        rom[8'h02] = 16'h9ABC;
        rom[8'h10] = 16'h0FFE;
        rom[8'h20] = 16'h3456;
        rom[8'hEF] = 16'h1111;
        rom[8'hF0] = 16'h0ABC;
        rom[8'hFF] = 16'h7ABC;
        test_reset();
        test_fetch();
        test_stall();
        test_cond();
        test_back_to_back();
        rom[8'h00] = 16'h0FFE;
        test_wrap();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width in 16-bit words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mem_addr  output  ADDR_W  word address to synchronous instruction ROM, equal to pc[ADDR_W-1:0].
REQ-005 SHALL have port mem_q  input  16  ROM data, valid the cycle after mem_addr is sampled by the ROM.
REQ-006 SHALL have port pc  output  32  program counter.
REQ-007 SHALL have port inst  output  16  instruction register.
REQ-008 SHALL have port codop/s4/s3/s2  output  4 each  inst[15:12]/[11:8]/[7:4]/[3:0].
REQ-009 SHALL have port imm  output  12  inst[11:0].
REQ-010 SHALL have port inst_valid  output  1  inst holds a fresh instruction for decode.
REQ-011 SHALL have port inst_ready  input  1  decode accepts inst this cycle.
REQ-012 SHALL have port EscCP  input  1  unconditional PC redirect.
REQ-013 SHALL have port EscCondCP  input  1  conditional PC redirect, gated by cond.
REQ-014 SHALL have port cond  input  1  branch condition from ULA.
REQ-015 SHALL have port FonteCP  input  2  redirect-target select.
REQ-016 SHALL have port alvo  input  16  register operand for indirect jump.
REQ-017 SHALL have port EscLR  input  1  write link register.
REQ-018 SHALL have port lr  output  32  link register.

Function
REQ-019 SHALL implement FSM BUSCA -> ESPERA -> ENTREGA -> BUSCA.
REQ-020 BUSCA: mem_addr driven from pc; next state ESPERA unconditionally, absent redirect.
REQ-021 ESPERA: inst <= mem_q at edge; next state ENTREGA.
REQ-022 ENTREGA: inst_valid=1, inst held stable; on inst_ready=1: pc <= pc+1, next state BUSCA; else remain.
REQ-023 inst_valid SHALL be 1 only in ENTREGA; no-redirect throughput is one instruction per 3 cycles.
REQ-024 take = EscCP | (EscCondCP & cond), evaluated every cycle in every state.
REQ-025 take=1: pc <= target, next state BUSCA, any in-flight fetch discarded, inst_valid 0 next cycle; inst unchanged.
REQ-026 Targets: FonteCP=00 pc+1; 01 pc+1+signext(inst[11:0]); 10 {pc[31:12],inst[11:0]}; 11 {16'b0,alvo}.
REQ-027 Redirect SHALL take priority over the ENTREGA handshake when both occur in one cycle; pc+1 increment suppressed.
REQ-028 EscLR=1: lr <= pc+1 computed from pre-edge pc, independent of take in same cycle.
REQ-029 pc arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFF+1 = 0); mem_addr wraps with pc low bits.
REQ-030 Relative target sign-extends 12 to 32 bits; 0x800 = -2048.
REQ-031 Field outputs SHALL be combinational slices of inst.

Reset
REQ-032 reset=1 SHALL immediately force pc=0, inst=0, lr=0, inst_valid=0, state BUSCA, regardless of clk.
REQ-033 After reset release, first fetch SHALL present mem_addr=0 in the first cycle.
REQ-034 Reset asserted mid-fetch or during ENTREGA SHALL discard the pending instruction; no inst_valid pulse follows.

Verification
REQ-035 Reset release, ROM[0]=0x1234, ROM[1]=0x5678, inst_ready=1 -> inst_valid cycle 3 with inst=0x1234 (codop=1,s4=2,s3=3,s2=4), cycle 6 with 0x5678, pc=2 after.
REQ-036 inst_ready=0 for 5 cycles in ENTREGA -> inst and pc stable, inst_valid held 1; accepted on cycle ready=1.
REQ-037 pc=0x10, inst=0x0FFE, EscCondCP=1, FonteCP=01: cond=0 -> no redirect; cond=1 -> pc=0x0F, state BUSCA.
REQ-038 ENTREGA with inst_ready=1, EscCP=1, FonteCP=11, alvo=0xBEEF, EscLR=1, pc=0x20 -> pc=0x0000BEEF, lr=0x21, no increment.
REQ-039 pc=0xFFFFFFFF, ADDR_W=8, accepted -> pc=0, mem_addr=0x00; FonteCP=10 with inst=0x0ABC at pc=0x1234_5000 -> pc=0x1234_5ABC.
REQ-040 reset pulsed during ESPERA -> outputs zero immediately; after release fetch restarts at address 0.
